// File: rtl/video_pkg.sv
// Shared constants and types for the RGB555 test-pattern generator.
package video_pkg;

  localparam int unsigned HActive = 640;
  localparam int unsigned VActive = 480;

  // RGB555 field layout: {R[14:10], G[9:5], B[4:0]}
  localparam int unsigned PixW  = 15;
  localparam int unsigned ChanW = 5;
  localparam int unsigned RLsb  = 10;
  localparam int unsigned GLsb  = 5;
  localparam int unsigned BLsb  = 0;

  typedef enum logic [1:0] {
    PatSolid = 2'd0,
    PatBars  = 2'd1,
    PatCheck = 2'd2,
    PatGrad  = 2'd3
  } pattern_e;

  // White, yellow, cyan, green, magenta, red, blue, black
  localparam logic [PixW-1:0] BarColors [8] = '{
    15'h7FFF, 15'h7FE0, 15'h03FF, 15'h03E0,
    15'h7C1F, 15'h7C00, 15'h001F, 15'h0000
  };

endpackage

// File: rtl/video_timing_tracker.sv
// Follows the driver's DE/VSYNC to keep pixel, line and frame position, the latched
// pattern mode and colour-bar index; exports the coordinates of the pixel being prepared.
module video_timing_tracker
  import video_pkg::*;
#(
  parameter int unsigned BarW = 80
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      de_i,
  input  logic      v_i,
  input  logic [1:0] sel_i,
  output logic [10:0] pix_x_o,
  output logic [9:0]  pix_y_o,
  output logic [7:0]  frame_cnt_o,
  output pattern_e    mode_o,
  output logic [10:0] next_x_o,
  output logic [2:0]  next_bar_o
);

  localparam int unsigned BarCntW = (BarW > 1) ? $clog2(BarW) : 1;

  logic               de_q, v_q;
  logic               de_fall, v_fall;
  logic [10:0]        pix_x_q, pix_x_d;
  logic [9:0]         pix_y_q, pix_y_d;
  logic [7:0]         frame_q, frame_d;
  pattern_e           mode_q, mode_d;
  logic [2:0]         bar_q, bar_d;
  logic [BarCntW-1:0] bar_cnt_q, bar_cnt_d;

  always_comb begin
    de_fall   = de_q & ~de_i;
    v_fall    = v_q & ~v_i;
    pix_x_d   = '0;
    bar_d     = '0;
    bar_cnt_d = '0;
    if (de_i) begin
      pix_x_d = (pix_x_q == 11'h7FF) ? pix_x_q : pix_x_q + 11'd1;
      // Bar index advances on the pixel after the last one of the current bar.
      if (bar_cnt_q == BarCntW'(BarW - 1)) begin
        bar_cnt_d = '0;
        bar_d     = (bar_q == 3'd7) ? bar_q : bar_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 1'b1;
        bar_d     = bar_q;
      end
    end

    pix_y_d = pix_y_q;
    if (!v_i) begin
      pix_y_d = '0;
    end else if (de_fall && (pix_y_q != 10'h3FF)) begin
      pix_y_d = pix_y_q + 10'd1;
    end

    frame_d = frame_q;
    mode_d  = mode_q;
    if (v_fall) begin
      frame_d = frame_q + 8'd1;
      mode_d  = pattern_e'(sel_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      de_q      <= 1'b0;
      v_q       <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      frame_q   <= '0;
      mode_q    <= PatSolid;
      bar_q     <= '0;
      bar_cnt_q <= '0;
    end else begin
      de_q      <= de_i;
      v_q       <= v_i;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      frame_q   <= frame_d;
      mode_q    <= mode_d;
      bar_q     <= bar_d;
      bar_cnt_q <= bar_cnt_d;
    end
  end

  assign pix_x_o     = pix_x_q;
  assign pix_y_o     = pix_y_q;
  assign frame_cnt_o = frame_q;
  assign mode_o      = mode_q;
  assign next_x_o    = pix_x_d;
  assign next_bar_o  = bar_d;

endmodule

// File: rtl/video_pattern_gen.sv
// RGB555 test-pattern source for the CH7301C driver: solid, colour bars, animated
// checker or gradient, with pix_data registered so it lines up with DE.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = HActive,
  parameter int unsigned BAR_W       = H_ACTIVE / 8,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned ANIM_BIT    = 5,
  parameter logic [14:0] SOLID_COLOR = 15'h7C00
) (
  input  logic        clk25_2,
  input  logic        rst_n,
  input  logic        dvi_de,
  input  logic        dvi_v,
  input  logic [1:0]  pattern_sel,
  output logic [14:0] pix_data,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [7:0]  frame_cnt
);

  pattern_e          mode;
  logic [10:0]       next_x;
  logic [2:0]        next_bar;
  logic [ChanW-1:0]  grad_x, grad_y;
  logic [PixW-1:0]   pat;
  logic [PixW-1:0]   pix_data_q, pix_data_d;
  logic              unused_bits;

  video_timing_tracker #(
    .BarW (BAR_W)
  ) u_tracker (
    .clk_i       (clk25_2),
    .rst_ni      (rst_n),
    .de_i        (dvi_de),
    .v_i         (dvi_v),
    .sel_i       (pattern_sel),
    .pix_x_o     (pix_x),
    .pix_y_o     (pix_y),
    .frame_cnt_o (frame_cnt),
    .mode_o      (mode),
    .next_x_o    (next_x),
    .next_bar_o  (next_bar)
  );

  // Pattern is evaluated for the pixel that will be on the wire next cycle.
  always_comb begin
    grad_x = next_x[8:4];
    grad_y = pix_y[8:4];
    pat    = '0;
    unique case (mode)
      PatSolid: pat = SOLID_COLOR;
      PatBars:  pat = BarColors[next_bar];
      PatCheck: pat = (next_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2] ^ frame_cnt[ANIM_BIT]) ?
                      15'h7FFF : 15'h0000;
      PatGrad:  pat = {grad_x, grad_y, grad_x ^ grad_y};
    endcase
    pix_data_d = dvi_v ? pat : '0;
  end

  always_ff @(posedge clk25_2 or negedge rst_n) begin
    if (!rst_n) begin
      pix_data_q <= '0;
    end else begin
      pix_data_q <= pix_data_d;
    end
  end

  assign pix_data    = pix_data_q;
  assign unused_bits = ^{next_x, pix_y};

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed plus randomized bench for video_pattern_gen against an event-counting model.
module tb_video_pattern_gen;

  logic        clk25_2 = 1'b0;
  logic        rst_n   = 1'b1;
  logic        dvi_de  = 1'b0;
  logic        dvi_v   = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [14:0] pix_data;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: DE index, line, frames seen, latched mode, last-cycle inputs
  int m_x, m_line, m_frame, m_mode;
  bit m_last_de, m_last_v;

  logic [14:0] bar_tbl [8] = '{15'h7FFF, 15'h7FE0, 15'h03FF, 15'h03E0,
                               15'h7C1F, 15'h7C00, 15'h001F, 15'h0000};

  video_pattern_gen dut (
    .clk25_2     (clk25_2),
    .rst_n       (rst_n),
    .dvi_de      (dvi_de),
    .dvi_v       (dvi_v),
    .pattern_sel (pattern_sel),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_cnt   (frame_cnt)
  );

  always #20 clk25_2 = ~clk25_2;

  initial begin
    #8000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [14:0] ref_pix(int x, int y, int mode, int frame);
    int r, g, bi;
    case (mode)
      0: return 15'h7C00;
      1: begin
        bi = x / 80;
        if (bi > 7) bi = 7;
        return bar_tbl[bi];
      end
      2: return ((((x >> 5) ^ (y >> 5) ^ (frame >> 5)) & 1) != 0) ? 15'h7FFF : 15'h0000;
      default: begin
        r = (x >> 4) % 32;
        g = (y >> 4) % 32;
        return 15'((r << 10) | (g << 5) | (r ^ g));
      end
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_line = 0; m_frame = 0; m_mode = 0;
    m_last_de = 1'b0; m_last_v = 1'b0;
  endtask

  // One pixel clock: apply inputs, check the cycle, then advance the model over the edge.
  task automatic cyc(input bit de, input bit v);
    bit de_fall, v_fall;
    dvi_de = de;
    dvi_v  = v;
    #1;
    chk("pix_x", 32'(pix_x), m_x);
    chk("pix_y", 32'(pix_y), m_line);
    chk("frame_cnt", 32'(frame_cnt), m_frame);
    if (de) begin
      if (!m_last_v) chk("pix_data_vblank_de", 32'(pix_data), 0);
      else chk("pix_data", 32'(pix_data), 32'(ref_pix(m_x, m_line, m_mode, m_frame)));
    end else if (!m_last_v && !v) begin
      chk("pix_data_vblank", 32'(pix_data), 0);
    end
    @(posedge clk25_2);
    #1;
    de_fall = m_last_de && !de;
    v_fall  = m_last_v && !v;
    m_x = de ? ((m_x + 1 > 2047) ? 2047 : m_x + 1) : 0;
    if (!v) m_line = 0;
    else if (de_fall) m_line = (m_line + 1 > 1023) ? 1023 : m_line + 1;
    if (v_fall) begin
      m_frame = (m_frame + 1) % 256;
      m_mode  = int'(pattern_sel);
    end
    m_last_de = de;
    m_last_v  = v;
  endtask

  task automatic line(input int len, input int blank);
    for (int i = 0; i < len; i++) cyc(1'b1, 1'b1);
    for (int i = 0; i < blank; i++) cyc(1'b0, 1'b1);
  endtask

  task automatic vsync(input int low, input int high);
    for (int i = 0; i < low; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < high; i++) cyc(1'b0, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix_data"}, 32'(pix_data), 0);
    chk({tag, "_pix_x"}, 32'(pix_x), 0);
    chk({tag, "_pix_y"}, 32'(pix_y), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
  endtask

  initial begin
    model_reset();
    #5 rst_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk25_2);
    #1;
    rst_n = 1'b1;

    // Colour bars over full lines
    pattern_sel = 2'd1;
    vsync(2, 2);
    repeat (2) line(640, 4);

    // Checker across the 32-pixel and 32-line boundaries
    pattern_sel = 2'd2;
    vsync(2, 2);
    repeat (34) line(70, 3);

    // Gradient, including x wrap at 512 and pix_x saturation
    pattern_sel = 2'd3;
    vsync(2, 2);
    repeat (18) line(600, 3);
    line(2100, 3);

    // Mode change mid-frame must wait for the next VSYNC
    pattern_sel = 2'd0;
    vsync(2, 2);
    repeat (100) line(8, 2);
    pattern_sel = 2'd3;
    repeat (5) line(64, 2);
    vsync(2, 2);
    repeat (17) line(64, 2);

    // Randomized frames with per-line pattern_sel churn
    for (int f = 0; f < 4; f++) begin
      vsync($urandom_range(3, 1), $urandom_range(3, 1));
      for (int l = 0; l < int'($urandom_range(10, 1)); l++) begin
        pattern_sel = 2'($urandom);
        line($urandom_range(700, 1), $urandom_range(6, 2));
      end
    end

    // Coincident DE fall and VSYNC fall, then DE while VSYNC low
    line(12, 2);
    repeat (5) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);

    // Frame counter wrap, then reach an animated checker phase
    pattern_sel = 2'd2;
    repeat (256) vsync(1, 1);
    for (int k = 0; k < 64 && ((m_frame >> 5) & 1) == 0; k++) vsync(1, 1);
    vsync(1, 1);
    repeat (34) line(70, 3);

    // Line counter saturation
    pattern_sel = 2'd3;
    vsync(2, 2);
    repeat (1030) line(1, 2);

    // Reset mid-line, then recovery into bars mode
    pattern_sel = 2'd1;
    vsync(2, 2);
    line(300, 3);
    repeat (10) cyc(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_zero("midline_reset");
    @(posedge clk25_2);
    #1;
    dvi_de = 1'b0;
    dvi_v  = 1'b1;
    @(posedge clk25_2);
    #1;
    rst_n = 1'b1;
    model_reset();
    vsync(2, 2);
    line(640, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
